wf_gather_ctrl: RTL and testbench
=================================

Name: wf_gather_ctrl

Overview:
- Sequencer and arbiter for the 8-entry x 39-bit wavefront gather RAM. The RAM is 1R1W with a registered read address, so read data appears 1 cycle after R0_en.
- Two producers push wavefront records through a round-robin arbiter. The block uses the RAM as a circular buffer and drains records in order to one consumer over a valid/ready interface.
- Sits between the wavefront-completion sources and the CTA-scheduler gather stage. Owns all RAM port control.

Parameters:
- DEPTH, 8, number of RAM entries; must be a power of 2.
- AW, 3, RAM address width; log2(DEPTH).
- DW, 39, record width.

Ports:
- clock  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  producer 0 has a record.
- req0_ready  out  1  producer 0 record accepted this cycle.
- req0_data  in  DW  producer 0 record.
- req1_valid  in  1  producer 1 has a record.
- req1_ready  out  1  producer 1 record accepted this cycle.
- req1_data  in  DW  producer 1 record.
- out_valid  out  1  out_data holds a record.
- out_ready  in  1  consumer accepts.
- out_data  out  DW  drained record.
- count  out  AW+1  records owned by the block (in RAM + in flight + out register).
- ram_w_en  out  1  to W0_en.
- ram_w_addr  out  AW  to W0_addr.
- ram_w_data  out  DW  to W0_data.
- ram_r_en  out  1  to R0_en.
- ram_r_addr  out  AW  to R0_addr.
- ram_r_data  in  DW  from R0_data.

Behaviour:
- Reset state (asynchronous, active-high): wr_ptr=0, rd_ptr=0, pending=0, count=0, rr_pri=0 (producer 0 preferred), rd_inflight=0, out_valid=0, out_data=0. All ram_* outputs are combinational and evaluate low while reset is held.
- Reset mid-operation: every record in flight or queued is discarded. RAM contents are not cleared. Stale entries are never read because pending=0.
- Full condition: full = (count == DEPTH).
- Arbiter, combinational:
  - No grant if full.
  - If exactly one requester is valid, it is granted.
  - If both are valid, the requester selected by rr_pri is granted. After that grant, rr_pri flips to point at the other requester.
  - rr_pri changes only when both requesters were valid in the same cycle.
  - reqN_ready = grant N. At most one ready per cycle.
- Write: on a grant, ram_w_en=1, ram_w_addr=wr_ptr, ram_w_data=granted data. wr_ptr increments mod DEPTH. pending increments.
- Read issue: allowed when pending>0, rd_inflight=0, and (out_valid=0 or out_ready=1).
  - On issue: ram_r_en=1, ram_r_addr=rd_ptr, rd_ptr increments mod DEPTH, pending decrements, rd_inflight set to 1.
- Capture: in the cycle with rd_inflight=1, ram_r_data is valid. At the end of that cycle out_data<=ram_r_data, out_valid<=1, rd_inflight<=0.
- Latency: record written at edge t can issue a read in cycle t+1 and appear on out_valid from cycle t+3. Maximum drain throughput is 1 record per 2 cycles.
- Output handshake:
  - out_valid=1 and out_ready=1: pop. out_valid clears unless a capture occurs in the same cycle.
  - out_data is held stable while out_valid=1 and out_ready=0.
- count: +1 on grant, -1 on pop. Both in the same cycle leaves count unchanged. count never exceeds DEPTH.
- Same-address hazard: a write and a read to the same address in one cycle is impossible, because a read only targets pending entries and a write requires !full.
- Wrap-around: both pointers wrap DEPTH-1 -> 0 with no gap.

Optional Feature:
- Macro: WF_GATHER_CTRL_STATS_EN.
- When defined:
  - Adds output port stall_cnt, 16 bits.
  - The counter increments each cycle in which (req0_valid or req1_valid) and full.
  - It saturates at 0xFFFF and resets to 0.
- When undefined: the port and counter are absent. Behaviour is otherwise identical.

Test Plan:
- Reset, then req0 pushes 0x11 with out_ready=1 -> ram_w_addr=0 at cycle 0, ram_r_en at cycle 1, out_valid=1 with out_data=0x11 at cycle 3; count goes 1 then 0 after the pop.
- Both producers valid for 4 cycles (data 0xA0.., 0xB0..), out_ready=1 -> grants alternate 0,1,0,1; output order A0,B0,A1,B1.
- out_ready=0, req0 pushes 9 records -> 8 accepted, then req0_ready=0 and count=8. Raise out_ready -> one accepted write per pop. Output sequence in order, including across the pointer wrap 7 -> 0.
- Backpressure: out_valid=1, hold out_ready=0 for 5 cycles -> out_data stable, no ram_r_en. Release -> next record appears 2 cycles later.
- Assert reset with count=5 and out_valid=1 -> out_valid=0 and count=0 immediately. After release, a new push outputs only the new record.
- With WF_GATHER_CTRL_STATS_EN: fill to 8, hold req1_valid for 10 cycles -> stall_cnt=10. Reset -> stall_cnt=0.

Source files
------------

// File: rtl/wf_gather_ctrl.sv
// Round-robin gather sequencer: two producers -> 8-entry circular RAM -> one valid/ready consumer.
// Optional stall counter output enabled by defining WF_GATHER_CTRL_STATS_EN.
module wf_gather_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 39
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_data,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW:0]   count,
    output logic          ram_w_en,
    output logic [AW-1:0] ram_w_addr,
    output logic [DW-1:0] ram_w_data,
    output logic          ram_r_en,
    output logic [AW-1:0] ram_r_addr,
    input  logic [DW-1:0] ram_r_data
`ifdef WF_GATHER_CTRL_STATS_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   pending;
    logic          rr_pri;
    logic          rd_inflight;

    logic full;
    logic grant0;
    logic grant1;
    logic wr_fire;
    logic rd_fire;
    logic pop;

    always_comb begin
        full   = (count == (AW+1)'(DEPTH));
        grant0 = 1'b0;
        grant1 = 1'b0;
        // Reset gating keeps every RAM strobe and ready low while reset is held.
        if (!reset && !full) begin
            if (req0_valid && req1_valid) begin
                grant0 = !rr_pri;
                grant1 = rr_pri;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
        wr_fire = grant0 || grant1;
        rd_fire = !reset && (pending != '0) && !rd_inflight && (!out_valid || out_ready);
        pop     = out_valid && out_ready;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign ram_w_en   = wr_fire;
    assign ram_w_addr = wr_fire ? wr_ptr : '0;
    assign ram_w_data = wr_fire ? (grant1 ? req1_data : req0_data) : '0;
    assign ram_r_en   = rd_fire;
    assign ram_r_addr = rd_fire ? rd_ptr : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pending     <= '0;
            count       <= '0;
            rr_pri      <= 1'b0;
            rd_inflight <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            // Priority only rotates when the two producers actually contended.
            if (req0_valid && req1_valid && wr_fire) begin
                rr_pri <= ~rr_pri;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            pending     <= pending + (AW+1)'(wr_fire) - (AW+1)'(rd_fire);
            count       <= count + (AW+1)'(wr_fire) - (AW+1)'(pop);
            rd_inflight <= rd_fire;
            // Capture never collides with a held record: issue waits for a free or popping slot.
            if (rd_inflight) begin
                out_data  <= ram_r_data;
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef WF_GATHER_CTRL_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if ((req0_valid || req1_valid) && full && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wf_gather_ctrl.sv
// Directed bench for wf_gather_ctrl with a behavioural registered-read RAM model.
module tb_wf_gather_ctrl;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int DW    = 39;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DW-1:0] req0_data, req1_data;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic [AW:0]   count;
    logic          ram_w_en, ram_r_en;
    logic [AW-1:0] ram_w_addr, ram_r_addr;
    logic [DW-1:0] ram_w_data;
    logic [DW-1:0] ram_r_data;
`ifdef WF_GATHER_CTRL_STATS_EN
    logic [15:0]   stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] popq[$];
    logic [DW-1:0] mem[DEPTH];

    wf_gather_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clock(clk), .reset(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count),
        .ram_w_en(ram_w_en), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
        .ram_r_en(ram_r_en), .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data)
`ifdef WF_GATHER_CTRL_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
        if (ram_r_en) ram_r_data <= mem[ram_r_addr];
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) popq.push_back(out_data);
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_pops(input int n, input int budget, input string tag);
        int k = 0;
        while (popq.size() < n && k < budget) begin
            next();
            k++;
        end
        chk(tag, 64'(popq.size()), 64'(n));
    endtask

    initial begin
        int n0, n1, sent;
        logic [DW-1:0] e2[4];
        rst = 1'b1;
        req0_valid = 1'b1; req0_data = 39'h77;
        req1_valid = 1'b0; req1_data = '0;
        out_ready  = 1'b0;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count",     64'(count),     64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_w_en",      64'(ram_w_en),  64'd0);
        chk("rst_r_en",      64'(ram_r_en),  64'd0);
        chk("rst_ready0",    64'(req0_ready), 64'd0);
        next();
        rst = 1'b0;

        // Single push and latency
        req0_valid = 1'b1; req0_data = 39'h11; out_ready = 1'b1;
        smp();
        chk("t1_ready0", 64'(req0_ready), 64'd1);
        chk("t1_w_en",   64'(ram_w_en),   64'd1);
        chk("t1_w_addr", 64'(ram_w_addr), 64'd0);
        chk("t1_w_data", 64'(ram_w_data), 64'h11);
        next();
        req0_valid = 1'b0;
        smp();
        chk("t1_r_en",   64'(ram_r_en),   64'd1);
        chk("t1_r_addr", 64'(ram_r_addr), 64'd0);
        chk("t1_count1", 64'(count),      64'd1);
        chk("t1_ov_c1",  64'(out_valid),  64'd0);
        next();
        smp();
        chk("t1_r_en_c2", 64'(ram_r_en),  64'd0);
        chk("t1_ov_c2",   64'(out_valid), 64'd0);
        next();
        smp();
        chk("t1_ov_c3",   64'(out_valid), 64'd1);
        chk("t1_data_c3", 64'(out_data),  64'h11);
        chk("t1_cnt_c3",  64'(count),     64'd1);
        next();
        smp();
        chk("t1_ov_c4",  64'(out_valid), 64'd0);
        chk("t1_cnt_c4", 64'(count),     64'd0);
        next();

        // Contention: grants alternate 0,1,0,1
        popq.delete();
        n0 = 0; n1 = 0;
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'b1; req0_data = DW'(32'hA0 + n0);
            req1_valid = 1'b1; req1_data = DW'(32'hB0 + n1);
            smp();
            chk("t2_ready0", 64'(req0_ready), 64'(i % 2 == 0));
            chk("t2_ready1", 64'(req1_ready), 64'(i % 2 == 1));
            if (req0_ready) n0++;
            if (req1_ready) n1++;
            next();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_pops(4, 40, "t2_npops");
        e2[0] = 39'hA0; e2[1] = 39'hB0; e2[2] = 39'hA1; e2[3] = 39'hB1;
        for (int i = 0; i < 4; i++) chk("t2_order", 64'(popq[i]), 64'(e2[i]));

        // Fill to full, then drain across the pointer wrap
        popq.delete();
        out_ready = 1'b0; req0_valid = 1'b1; sent = 0;
        for (int j = 0; j < 9; j++) begin
            req0_data = DW'(32'hC0 + sent);
            smp();
            if (j == 0) chk("t3_waddr0", 64'(ram_w_addr), 64'd5);
            chk("t3_ready", 64'(req0_ready), 64'(j < 8));
            if (req0_ready) sent++;
            next();
        end
        smp();
        chk("t3_full_cnt", 64'(count), 64'd8);
        next();
        out_ready = 1'b1;
        for (int k = 0; k < 60 && sent < 12; k++) begin
            req0_data = DW'(32'hC0 + sent);
            smp();
            chk("t3_cnt_le8", 64'(count <= 4'd8), 64'd1);
            if (req0_ready) sent++;
            next();
        end
        req0_valid = 1'b0;
        chk("t3_sent", 64'(sent), 64'd12);
        wait_pops(12, 60, "t3_npops");
        for (int i = 0; i < 12; i++) chk("t3_order", 64'(popq[i]), 64'(32'hC0 + i));
        next();

        // Backpressure hold and release
        out_ready = 1'b0;
        req0_valid = 1'b1; req0_data = 39'hD0;
        next();
        req0_data = 39'hD1;
        next();
        req0_valid = 1'b0;
        next();
        for (int c = 0; c < 5; c++) begin
            smp();
            chk("t4_hold_ov",   64'(out_valid), 64'd1);
            chk("t4_hold_data", 64'(out_data),  64'hD0);
            chk("t4_hold_r_en", 64'(ram_r_en),  64'd0);
            next();
        end
        out_ready = 1'b1;
        smp();
        chk("t4_rel_ov",   64'(out_valid), 64'd1);
        chk("t4_rel_data", 64'(out_data),  64'hD0);
        chk("t4_rel_r_en", 64'(ram_r_en),  64'd1);
        next();
        smp();
        chk("t4_gap_ov", 64'(out_valid), 64'd0);
        next();
        smp();
        chk("t4_next_ov",   64'(out_valid), 64'd1);
        chk("t4_next_data", 64'(out_data),  64'hD1);
        next();
        smp();
        chk("t4_empty_cnt", 64'(count), 64'd0);
        next();

        // Reset mid-operation discards queued records
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req1_valid = 1'b1; req1_data = DW'(32'hE0 + i);
            next();
        end
        req1_valid = 1'b0;
        next();
        smp();
        chk("t5_pre_cnt", 64'(count),     64'd5);
        chk("t5_pre_ov",  64'(out_valid), 64'd1);
        next();
        rst = 1'b1;
        #1;
        chk("t5_rst_ov",  64'(out_valid), 64'd0);
        chk("t5_rst_cnt", 64'(count),     64'd0);
        next();
        rst = 1'b0;
        popq.delete();
        req0_valid = 1'b1; req0_data = 39'hF0; out_ready = 1'b1;
        next();
        req0_valid = 1'b0;
        wait_pops(1, 20, "t5_npops");
        repeat (10) next();
        chk("t5_only_one", 64'(popq.size()), 64'd1);
        chk("t5_new_data", 64'(popq[0]),     64'hF0);

        // Full boundary: blocked producer while full
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req0_valid = 1'b1; req0_data = DW'(32'h100 + i);
            next();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_data = 39'h1FF;
        smp();
        chk("t6_full_cnt", 64'(count),      64'd8);
        chk("t6_ready1",   64'(req1_ready), 64'd0);
        chk("t6_w_en",     64'(ram_w_en),   64'd0);
        next();
        repeat (9) next();
        req1_valid = 1'b0;
`ifdef WF_GATHER_CTRL_STATS_EN
        chk("t6_stall10", 64'(stall_cnt), 64'd10);
`endif
        rst = 1'b1;
        #1;
        chk("t6_rst_cnt", 64'(count), 64'd0);
`ifdef WF_GATHER_CTRL_STATS_EN
        chk("t6_rst_stall", 64'(stall_cnt), 64'd0);
`endif
        next();
        rst = 1'b0;
        repeat (2) next();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
